// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control chain: result/forward encodings
// and the packed control bundle carried by each pipeline stage register.
package pipe_ctrl_pkg;

    // Writeback source encodings
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;
    localparam logic [1:0] RESULT_IMM = 2'b11;

    // Operand forwarding selects
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Controls held in ID/EX (ALU function and register indices kept separately
    // because their widths are module parameters)
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       jalr;
    } ex_ctrl_t;

    // Controls held in EX/MEM
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } mem_ctrl_t;

    // Controls held in MEM/WB
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctrl_t;

    function automatic mem_ctrl_t ex_to_mem(input ex_ctrl_t c);
        mem_ctrl_t m;
        m.reg_write  = c.reg_write;
        m.result_src = c.result_src;
        m.mem_write  = c.mem_write;
        return m;
    endfunction

    function automatic wb_ctrl_t mem_to_wb(input mem_ctrl_t c);
        wb_ctrl_t w;
        w.reg_write  = c.reg_write;
        w.result_src = c.result_src;
        return w;
    endfunction

endpackage

// File: rtl/pipeline_control_chain_hazard.sv
// Combinational hazard unit: load-use stall, IF/ID flush, ID/EX bubble and
// operand forwarding selects. Register x0 never stalls and never forwards.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  valid_e,
    input  logic [1:0]            result_src_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  valid_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  valid_w,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  pc_src_e,
    output logic                  lw_stall,
    output logic                  flush_d,
    output logic                  bubble_e,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // Stall, flush and bubble decisions
    always_comb begin
        lw_stall = valid_e && (result_src_e == RESULT_MEM) && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));
        // On a simultaneous stall and redirect the flush squashes the stalled op
        flush_d  = pc_src_e;
        bubble_e = pc_src_e || lw_stall;
    end

    // Forwarding selects; MEM result is newer than WB so it wins
    always_comb begin
        mem_fwd_ok = valid_m && reg_write_m && (rd_m != '0);
        wb_fwd_ok  = valid_w && reg_write_w && (rd_w != '0);
        forward_a  = FWD_NONE;
        forward_b  = FWD_NONE;
        if (mem_fwd_ok && (rd_m == rs1_e)) begin
            forward_a = FWD_MEM;
        end else if (wb_fwd_ok && (rd_w == rs1_e)) begin
            forward_a = FWD_WB;
        end
        if (mem_fwd_ok && (rd_m == rs2_e)) begin
            forward_b = FWD_MEM;
        end else if (wb_fwd_ok && (rd_w == rs2_e)) begin
            forward_b = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_control_chain.sv
// Pipeline control chain: carries decoded controls through ID/EX, EX/MEM and
// MEM/WB, resolves branches/jumps in EX and drives stall/flush/forward selects.
// Optional macro PIPE_CTRL_PERF_EN adds bubble and redirect counters.
module pipeline_control_chain
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_FN_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write_d,
    input  logic                  alu_src_d,
    input  logic                  mem_write_d,
    input  logic                  beq_d,
    input  logic                  bne_d,
    input  logic                  jump_d,
    input  logic                  jalr_d,
    input  logic [1:0]            result_src_d,
    input  logic [ALU_FN_W-1:0]   alu_function_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  zero_e,
    output logic                  alu_src_e,
    output logic                  beq_e,
    output logic                  bne_e,
    output logic                  jump_e,
    output logic                  jalr_e,
    output logic [ALU_FN_W-1:0]   alu_function_e,
    output logic                  pc_src_e,
    output logic                  pc_jalr_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  mem_write_m,
    output logic [1:0]            result_src_w,
    output logic                  reg_write_w,
    output logic [REG_ADDR_W-1:0] rd_w,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]           bubble_count,
    output logic [31:0]           redirect_count,
`endif
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d
);

    // ID/EX
    logic                  valid_e_q;
    ex_ctrl_t              ctrl_e_q;
    logic [ALU_FN_W-1:0]   alu_fn_e_q;
    logic [REG_ADDR_W-1:0] rs1_e_q;
    logic [REG_ADDR_W-1:0] rs2_e_q;
    logic [REG_ADDR_W-1:0] rd_e_q;
    // EX/MEM
    logic                  valid_m_q;
    mem_ctrl_t             ctrl_m_q;
    logic [REG_ADDR_W-1:0] rd_m_q;
    // MEM/WB
    logic                  valid_w_q;
    wb_ctrl_t              ctrl_w_q;
    logic [REG_ADDR_W-1:0] rd_w_q;

    ex_ctrl_t ctrl_d;
    logic     lw_stall;
    logic     bubble_e;

    // Bundle decode-stage controls
    always_comb begin
        ctrl_d.reg_write  = reg_write_d;
        ctrl_d.result_src = result_src_d;
        ctrl_d.mem_write  = mem_write_d;
        ctrl_d.alu_src    = alu_src_d;
        ctrl_d.beq        = beq_d;
        ctrl_d.bne        = bne_d;
        ctrl_d.jump       = jump_d;
        ctrl_d.jalr       = jalr_d;
    end

    // EX-stage exports, gated by valid so bubbles never act; branch resolution
    always_comb begin
        alu_src_e      = valid_e_q & ctrl_e_q.alu_src;
        beq_e          = valid_e_q & ctrl_e_q.beq;
        bne_e          = valid_e_q & ctrl_e_q.bne;
        jump_e         = valid_e_q & ctrl_e_q.jump;
        jalr_e         = valid_e_q & ctrl_e_q.jalr;
        alu_function_e = valid_e_q ? alu_fn_e_q : '0;
        pc_src_e       = valid_e_q & (ctrl_e_q.jump | (ctrl_e_q.beq & zero_e) |
                                      (ctrl_e_q.bne & ~zero_e));
        pc_jalr_e      = valid_e_q & ctrl_e_q.jalr;
    end

    // MEM/WB exports; rd_w is deliberately left ungated
    always_comb begin
        mem_write_m  = valid_m_q & ctrl_m_q.mem_write;
        result_src_w = valid_w_q ? ctrl_w_q.result_src : 2'b00;
        reg_write_w  = valid_w_q & ctrl_w_q.reg_write;
        rd_w         = rd_w_q;
        stall_f      = lw_stall;
        stall_d      = lw_stall;
    end

    pipe_ctrl_hazard #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .valid_e      (valid_e_q),
        .result_src_e (ctrl_e_q.result_src),
        .rd_e         (rd_e_q),
        .rs1_e        (rs1_e_q),
        .rs2_e        (rs2_e_q),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .valid_m      (valid_m_q),
        .reg_write_m  (ctrl_m_q.reg_write),
        .rd_m         (rd_m_q),
        .valid_w      (valid_w_q),
        .reg_write_w  (ctrl_w_q.reg_write),
        .rd_w         (rd_w_q),
        .pc_src_e     (pc_src_e),
        .lw_stall     (lw_stall),
        .flush_d      (flush_d),
        .bubble_e     (bubble_e),
        .forward_a    (forward_a_e),
        .forward_b    (forward_b_e)
    );

    // Stage registers; later stages always advance, only ID/EX takes bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_e_q  <= 1'b0;
            ctrl_e_q   <= '0;
            alu_fn_e_q <= '0;
            rs1_e_q    <= '0;
            rs2_e_q    <= '0;
            rd_e_q     <= '0;
            valid_m_q  <= 1'b0;
            ctrl_m_q   <= '0;
            rd_m_q     <= '0;
            valid_w_q  <= 1'b0;
            ctrl_w_q   <= '0;
            rd_w_q     <= '0;
        end else begin
            valid_e_q  <= ~bubble_e;
            ctrl_e_q   <= ctrl_d;
            alu_fn_e_q <= alu_function_d;
            rs1_e_q    <= rs1_d;
            rs2_e_q    <= rs2_d;
            rd_e_q     <= rd_d;
            valid_m_q  <= valid_e_q;
            ctrl_m_q   <= ex_to_mem(ctrl_e_q);
            rd_m_q     <= rd_e_q;
            valid_w_q  <= valid_m_q;
            ctrl_w_q   <= mem_to_wb(ctrl_m_q);
            rd_w_q     <= rd_m_q;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] bubble_count_q;
    logic [31:0] redirect_count_q;

    // Event counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_count_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            if (bubble_e) bubble_count_q <= bubble_count_q + 32'd1;
            if (pc_src_e) redirect_count_q <= redirect_count_q + 32'd1;
        end
    end

    assign bubble_count   = bubble_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_pipeline_control_chain.sv
// Directed self-checking bench for pipeline_control_chain.
module tb_pipeline_control_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reg_write_d, alu_src_d, mem_write_d, beq_d, bne_d, jump_d, jalr_d;
    logic [1:0] result_src_d;
    logic [2:0] alu_function_d;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       zero_e;
    logic       alu_src_e, beq_e, bne_e, jump_e, jalr_e;
    logic [2:0] alu_function_e;
    logic       pc_src_e, pc_jalr_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       mem_write_m;
    logic [1:0] result_src_w;
    logic       reg_write_w;
    logic [4:0] rd_w;
    logic       stall_f, stall_d, flush_d;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] bubble_count, redirect_count;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_control_chain #(
        .REG_ADDR_W(5),
        .ALU_FN_W  (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_write_d    (reg_write_d),
        .alu_src_d      (alu_src_d),
        .mem_write_d    (mem_write_d),
        .beq_d          (beq_d),
        .bne_d          (bne_d),
        .jump_d         (jump_d),
        .jalr_d         (jalr_d),
        .result_src_d   (result_src_d),
        .alu_function_d (alu_function_d),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rd_d           (rd_d),
        .zero_e         (zero_e),
        .alu_src_e      (alu_src_e),
        .beq_e          (beq_e),
        .bne_e          (bne_e),
        .jump_e         (jump_e),
        .jalr_e         (jalr_e),
        .alu_function_e (alu_function_e),
        .pc_src_e       (pc_src_e),
        .pc_jalr_e      (pc_jalr_e),
        .forward_a_e    (forward_a_e),
        .forward_b_e    (forward_b_e),
        .mem_write_m    (mem_write_m),
        .result_src_w   (result_src_w),
        .reg_write_w    (reg_write_w),
        .rd_w           (rd_w),
`ifdef PIPE_CTRL_PERF_EN
        .bubble_count   (bubble_count),
        .redirect_count (redirect_count),
`endif
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic rw, input logic [1:0] rsrc, input logic mw,
                         input logic asrc, input logic bq, input logic bn, input logic jp,
                         input logic jr, input logic [2:0] fn, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rdd);
        reg_write_d    = rw;
        result_src_d   = rsrc;
        mem_write_d    = mw;
        alu_src_d      = asrc;
        beq_d          = bq;
        bne_d          = bn;
        jump_d         = jp;
        jalr_d         = jr;
        alu_function_d = fn;
        rs1_d          = r1;
        rs2_d          = r2;
        rd_d           = rdd;
    endtask

    task automatic nop();
        set_d(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
        zero_e = 1'b0;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    task automatic randomize_d();
        set_d(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom));
        zero_e = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        randomize_d();
        tick();
        randomize_d();
        tick();
        rst_n = 1'b1;
        randomize_d();
        @(negedge clk);
        total++;
        if (reg_write_w !== 1'b0) begin
            bad++; $display("FAIL reset_reg_write_w: got %b want 0", reg_write_w);
        end
        total++;
        if (mem_write_m !== 1'b0) begin
            bad++; $display("FAIL reset_mem_write_m: got %b want 0", mem_write_m);
        end
        total++;
        if (pc_src_e !== 1'b0) begin
            bad++; $display("FAIL reset_pc_src_e: got %b want 0", pc_src_e);
        end
        total++;
        if (stall_f !== 1'b0) begin
            bad++; $display("FAIL reset_stall_f: got %b want 0", stall_f);
        end
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b0000) begin
            bad++; $display("FAIL reset_forward: got %b want 0000", {forward_a_e, forward_b_e});
        end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        // add x5,x1,x2 ; sub x6,x5,x1
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd1, 5'd5, 5'd1, 5'd6);
        @(negedge clk);
        total++;
        if (forward_a_e !== 2'b00) begin
            bad++; $display("FAIL b2b_add_fwd_a: got %b want 00", forward_a_e);
        end
        tick();
        nop();
        @(negedge clk);
        total++;
        if (forward_a_e !== 2'b10) begin
            bad++; $display("FAIL b2b_sub_fwd_a: got %b want 10", forward_a_e);
        end
        total++;
        if (forward_b_e !== 2'b00) begin
            bad++; $display("FAIL b2b_sub_fwd_b: got %b want 00", forward_b_e);
        end
        total++;
        if (alu_function_e !== 3'd1) begin
            bad++; $display("FAIL b2b_alu_fn_e: got %0d want 1", alu_function_e);
        end
        tick();
        @(negedge clk);
        total++;
        if ({reg_write_w, rd_w} !== {1'b1, 5'd5}) begin
            bad++; $display("FAIL b2b_wb: got rw=%b rd=%0d want rw=1 rd=5", reg_write_w, rd_w);
        end
        drain();
    endtask

    task automatic test_gap_forward();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd3, 5'd4, 5'd9);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd1, 5'd5, 5'd1, 5'd6);
        tick();
        nop();
        @(negedge clk);
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b0100) begin
            bad++; $display("FAIL gap_fwd: got %b want 0100", {forward_a_e, forward_b_e});
        end
        drain();
    endtask

    task automatic test_mem_priority();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd2, 5'd3, 5'd5);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd1, 5'd5, 5'd5, 5'd6);
        tick();
        nop();
        @(negedge clk);
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b1010) begin
            bad++; $display("FAIL mem_priority: got %b want 1010", {forward_a_e, forward_b_e});
        end
        drain();
    endtask

    task automatic test_load_use();
        // lw x7,0(x1)
        set_d(1, 2'b01, 0, 1, 0, 0, 0, 0, 3'd0, 5'd1, 5'd0, 5'd7);
        tick();
        // add x8,x7,x2
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd2, 5'd7, 5'd2, 5'd8);
        @(negedge clk);
        total++;
        if ({stall_f, stall_d, flush_d} !== 3'b110) begin
            bad++; $display("FAIL lu_stall: got sf,sd,fd=%b want 110", {stall_f, stall_d, flush_d});
        end
        tick();
        @(negedge clk);
        total++;
        if ({stall_f, stall_d} !== 2'b00) begin
            bad++; $display("FAIL lu_stall_one_cycle: got %b want 00", {stall_f, stall_d});
        end
        total++;
        if (alu_function_e !== 3'd0) begin
            bad++; $display("FAIL lu_bubble_alu_fn: got %0d want 0", alu_function_e);
        end
        tick();
        nop();
        @(negedge clk);
        total++;
        if ({forward_a_e, forward_b_e, alu_function_e} !== {2'b01, 2'b00, 3'd2}) begin
            bad++; $display("FAIL lu_fwd: got a=%b b=%b fn=%0d want a=01 b=00 fn=2",
                            forward_a_e, forward_b_e, alu_function_e);
        end
        total++;
        if ({reg_write_w, result_src_w, rd_w} !== {1'b1, 2'b01, 5'd7}) begin
            bad++; $display("FAIL lu_wb: got rw=%b rs=%b rd=%0d want rw=1 rs=01 rd=7",
                            reg_write_w, result_src_w, rd_w);
        end
        drain();
    endtask

    task automatic test_taken_beq();
        set_d(0, 2'b00, 0, 0, 1, 0, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0);
        tick();
        // op behind the branch, to be squashed
        set_d(1, 2'b00, 1, 1, 0, 0, 0, 0, 3'd5, 5'd3, 5'd4, 5'd10);
        zero_e = 1'b1;
        @(negedge clk);
        total++;
        if ({pc_src_e, flush_d, pc_jalr_e, beq_e} !== 4'b1101) begin
            bad++; $display("FAIL beq_taken: got pc,fl,jr,beq=%b want 1101",
                            {pc_src_e, flush_d, pc_jalr_e, beq_e});
        end
        tick();
        nop();
        @(negedge clk);
        total++;
        if ({alu_src_e, alu_function_e, pc_src_e} !== {1'b0, 3'd0, 1'b0}) begin
            bad++; $display("FAIL beq_bubble: got asrc=%b fn=%0d pc=%b want 0 0 0",
                            alu_src_e, alu_function_e, pc_src_e);
        end
        tick();
        @(negedge clk);
        total++;
        if (mem_write_m !== 1'b0) begin
            bad++; $display("FAIL beq_squash_mem_write: got %b want 0", mem_write_m);
        end
        tick();
        @(negedge clk);
        total++;
        if (reg_write_w !== 1'b0) begin
            bad++; $display("FAIL beq_squash_reg_write: got %b want 0", reg_write_w);
        end
        drain();
    endtask

    task automatic test_bne_and_jalr();
        set_d(0, 2'b00, 0, 0, 0, 1, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0);
        tick();
        nop();
        zero_e = 1'b1;
        @(negedge clk);
        total++;
        if ({pc_src_e, flush_d, bne_e} !== 3'b001) begin
            bad++; $display("FAIL bne_not_taken: got pc,fl,bne=%b want 001",
                            {pc_src_e, flush_d, bne_e});
        end
        zero_e = 1'b0;
        #1;
        total++;
        if ({pc_src_e, flush_d} !== 2'b11) begin
            bad++; $display("FAIL bne_taken: got pc,fl=%b want 11", {pc_src_e, flush_d});
        end
        drain();
        // jalr x1, 0(x3)
        set_d(1, 2'b10, 0, 1, 0, 0, 1, 1, 3'd0, 5'd3, 5'd0, 5'd1);
        tick();
        nop();
        @(negedge clk);
        total++;
        if ({pc_src_e, pc_jalr_e, jump_e, jalr_e, flush_d} !== 5'b11111) begin
            bad++; $display("FAIL jalr: got pc,pj,j,jr,fl=%b want 11111",
                            {pc_src_e, pc_jalr_e, jump_e, jalr_e, flush_d});
        end
        drain();
    endtask

    task automatic test_x0();
        set_d(1, 2'b01, 0, 1, 0, 0, 0, 0, 3'd0, 5'd1, 5'd0, 5'd0);
        tick();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd8);
        @(negedge clk);
        total++;
        if ({stall_f, stall_d} !== 2'b00) begin
            bad++; $display("FAIL x0_no_stall: got %b want 00", {stall_f, stall_d});
        end
        tick();
        nop();
        @(negedge clk);
        total++;
        if ({forward_a_e, forward_b_e} !== 4'b0000) begin
            bad++; $display("FAIL x0_no_fwd: got %b want 0000", {forward_a_e, forward_b_e});
        end
        drain();
    endtask

    task automatic test_mid_reset();
        set_d(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd5);
        tick();
        set_d(0, 2'b00, 1, 1, 0, 0, 0, 0, 3'd0, 5'd1, 5'd5, 5'd0);
        tick();
        nop();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({reg_write_w, mem_write_m, rd_w} !== {1'b0, 1'b0, 5'd0}) begin
            bad++; $display("FAIL mid_reset: got rw=%b mw=%b rd=%0d want 0 0 0",
                            reg_write_w, mem_write_m, rd_w);
        end
        tick();
        @(negedge clk);
        total++;
        if ({reg_write_w, mem_write_m} !== 2'b00) begin
            bad++; $display("FAIL mid_reset_after: got rw=%b mw=%b want 0 0",
                            reg_write_w, mem_write_m);
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        test_reset();
        test_back_to_back();
        test_gap_forward();
        test_mem_priority();
        test_load_use();
        test_taken_beq();
        test_bne_and_jalr();
        test_x0();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control_chain.md
Name: pipeline_control_chain

Overview:
- Carries decoded control signals from the decode-stage controller through the ID/EX, EX/MEM and MEM/WB pipeline registers of the five-stage RISC-V core.
- Resolves branch and jump redirects in EX and detects load-use hazards.
- Generates forwarding selects, stall signals and flush signals.
- Sits directly downstream of the decode controller; its outputs drive the execute, memory and writeback datapath muxes and the IF/ID register enables.

Parameters:
- REG_ADDR_W, 5, register-index width.
- ALU_FN_W, 3, alu_function width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- reg_write_d, alu_src_d, mem_write_d, beq_d, bne_d, jump_d, jalr_d  in  1 each  decode-stage controls.
- result_src_d  in  2  writeback source.
- alu_function_d  in  ALU_FN_W  ALU operation.
- rs1_d, rs2_d, rd_d  in  REG_ADDR_W  decode register indices.
- zero_e  in  1  ALU zero flag, EX stage.
- alu_src_e, beq_e, bne_e, jump_e, jalr_e  out  1  EX-stage controls.
- alu_function_e  out  ALU_FN_W  EX-stage ALU operation.
- pc_src_e  out  1  redirect PC (taken branch or jump).
- pc_jalr_e  out  1  redirect target is ALU result (jalr).
- forward_a_e, forward_b_e  out  2  operand forwarding selects.
- mem_write_m  out  1  data-memory write enable.
- result_src_w  out  2  writeback mux select.
- reg_write_w  out  1  register-file write enable.
- rd_w  out  REG_ADDR_W  register-file write index.
- stall_f, stall_d  out  1  hold PC and IF/ID.
- flush_d  out  1  clear IF/ID.

Behaviour:
- Reset: while rst_n=0 at a clock edge, every pipeline register and valid bit clears to 0. All outputs read 0 (forward selects 2'b00, pc_src_e=0) from the following cycle.
- Each stage register holds a valid bit plus its controls. ID/EX also holds rs1, rs2 and rd; EX/MEM and MEM/WB hold rd.
- Valid gating:
  - Every exported control is ANDed with its stage's valid bit, so bubbles never write, branch or forward.
  - The rd values themselves are not gated.
- Result_src encoding: 00 ALU, 01 memory, 10 pc+4, 11 immediate.
- Branch resolution, combinational in EX:
  - pc_src_e = valid_e & (jump_e | (beq_e & zero_e) | (bne_e & ~zero_e)).
  - pc_jalr_e = valid_e & jalr_e.
  - The decoder asserts jump_d together with jalr_d for jalr.
- Load-use detection:
  - lw_stall = valid_e & result_src_e==01 & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
  - stall_f = stall_d = lw_stall.
- Flushes:
  - flush_d = pc_src_e.
  - The ID/EX bubble condition is pc_src_e | lw_stall.
- Register update each edge when rst_n=1:
  - ID/EX loads decode inputs with valid=1, or valid=0 on a bubble.
  - EX/MEM and MEM/WB always advance; no stall reaches EX or later.
- Forwarding, per operand A (rs1_e) and likewise B (rs2_e):
  - 2'b10 if valid_m & reg_write_m & rd_m!=0 & rd_m==rs1_e.
  - else 2'b01 if valid_w & reg_write_w & rd_w!=0 & rd_w==rs1_e.
  - else 2'b00. MEM has priority over WB.
- Simultaneous lw_stall and pc_src_e: the flush wins for IF/ID. The stall is also asserted, but the redirect is correct because the stalled instruction is squashed.
- x0 never forwards and never stalls.
- Latency: control entered in D appears as _e after 1 edge, mem_write_m after 2, reg_write_w after 3.
- Reset mid-operation: all in-flight instructions are discarded. No write enable may assert in the cycle after reset.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs bubble_count and redirect_count, each 32 bits, reset to 0.
  - bubble_count increments on each edge where an ID/EX bubble is inserted.
  - redirect_count increments on each edge where pc_src_e=1.
  - Both wrap modulo 2^32.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - RESULT_ALU/MEM/PC4/IMM constants.
  - FWD_NONE=00, FWD_WB=01, FWD_MEM=10.
  - A packed control-bundle typedef per stage.
- One sub-module, pipe_ctrl_hazard: combinational lw_stall, flush and forwarding logic. The stage registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 two cycles with random inputs -> reg_write_w=0, mem_write_m=0, pc_src_e=0, stall_f=0 on the cycle after release.
- Back-to-back ALU ops:
  - Issue add x5 then sub x6,x5,x1 -> forward_a_e=10 in the second op's EX.
  - Insert one unrelated op between them -> forward_a_e=01.
- Load-use: lw x7 then add x8,x7,x2 -> stall_f=stall_d=1 for exactly one cycle, one bubble (valid_e=0), then forward_a_e=01.
- Taken beq: beq_d=1 with zero_e=1 in EX -> pc_src_e=1, flush_d=1, the next EX slot is a bubble, and no mem_write_m or reg_write_w from the squashed op.
- Not-taken bne: bne_e=1, zero_e=1 -> pc_src_e=0, no flush. jalr (jump_d=1, jalr_d=1) -> pc_src_e=1, pc_jalr_e=1.
- x0 corner: lw x0 then add using x0 -> no stall, forward selects 00.
